mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port 16x16 unified memory between the multicycle CPU's instruction-fetch unit (read-only) and its data/stack unit (read/write).
- Owns all memory control outputs: address, write data, memrd, memwr. Memory reads are registered (data valid one edge after memrd is sampled).
- Provides one req/done handshake per requester and round-robin arbitration on simultaneous requests.

Parameters:
- ADDR_W, 16, width of the address bus to memory.
- DATA_W, 16, width of the data word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- f_req  input  1  fetch read request; held until f_done.
- f_addr  input  ADDR_W  fetch address; stable while f_req is high.
- f_done  output  1  one-cycle pulse; f_rdata is valid in the same cycle.
- f_rdata  output  DATA_W  fetched word; holds its value until the next fetch completes.
- d_req  input  1  data request; held until d_done.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_done  output  1  one-cycle completion pulse.
- d_rdata  output  DATA_W  read word; valid with d_done on reads, held otherwise.
- mem_abus  output  ADDR_W  address to memory.
- mem_dout  output  DATA_W  write data to memory (memory Dbusout).
- mem_din  input  DATA_W  read data from memory (memory Dbusin).
- memrd  output  1  memory read strobe.
- memwr  output  1  memory write strobe.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, synchronous and active-high: state = IDLE. All outputs are 0, including rdata registers, memrd, memwr, done pulses and busy. last_grant = DATA, so FETCH wins the first tie.
- All outputs are registered. There is no combinational path from req to memory strobes.
- States:
  - IDLE: if no req, stay. Otherwise select the owner:
    - only one req high: that requester;
    - both high: the requester that is not last_grant.
    - Register mem_abus = owner addr. Read: memrd = 1, go to RD_ISSUE. Write (data owner only): mem_dout = d_wdata, memwr = 1, go to WR_ISSUE. Update last_grant = owner.
  - RD_ISSUE: memory samples memrd on this edge. Deassert memrd, go to RD_CAPT.
  - RD_CAPT: capture mem_din into the owner's rdata register, pulse the owner's done, go to DONE.
  - WR_ISSUE: memory writes on this edge. Deassert memwr, pulse d_done, go to DONE.
  - DONE: one turnaround cycle so the requester can drop req. Go to IDLE.
- Latency, counted from the edge where IDLE samples req to the done pulse: reads 3 edges, writes 2 edges. The next grant is possible 2 cycles after done.
- memrd and memwr are each high for exactly one cycle per transaction and are never high together.
- mem_abus and mem_dout hold their last values between transactions. The done pulses are exactly 1 cycle.
- A req dropped mid-transaction is ignored; the transaction completes. A req still high in DONE is not re-granted until IDLE.
- Back-to-back, with both reqs held continuously, grants strictly alternate F, D, F, D.
- Reset mid-transaction aborts immediately: strobes drop in the same edge and no done pulse is issued. A memory write already sampled is not undone.
- Addresses pass through unmodified, all ADDR_W bits. Memory decode is the memory's concern.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings ARB_IDLE, ARB_RD_ISSUE, ARB_RD_CAPT, ARB_WR_ISSUE, ARB_DONE;
  - owner constants OWN_FETCH = 0, OWN_DATA = 1;
  - ADDR_W and DATA_W defaults.
- One sub-module is natural: rr_pick2, a 2-way round-robin selector taking req[1:0] and last_grant and returning a one-hot grant. It is purely combinational; the FSM holds last_grant.

Test Plan:
- Memory preloaded M[0] = 16'hF000-style program, M[14] = 3. f_req = 1, f_addr = 0 → memrd pulse with mem_abus = 0, f_done 3 edges later, f_rdata = M[0]; d_done stays 0.
- d_req = 1, d_we = 1, d_addr = 5, d_wdata = 16'hABCD → one-cycle memwr with mem_abus = 5 and mem_dout = 16'hABCD, d_done 2 edges later. A following d read of addr 5 returns 16'hABCD.
- After reset, f_req and d_req rise in the same cycle (d read of addr 14) → fetch granted first; d_done follows with d_rdata = 3. Holding both reqs yields strict alternation over 4 transactions.
- Reset asserted in RD_ISSUE → next cycle state IDLE, memrd = 0, busy = 0, no f_done pulse, f_rdata = 0.
- Continuous checks on every run: memrd and memwr never high together; each done is exactly 1 cycle wide; no memory strobe in the DONE or IDLE-without-req cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle CPU memory path: arbiter state
// encodings, requester identifiers and default bus widths.
package cpu_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 16;

   localparam logic [2:0] ARB_IDLE     = 3'd0;
   localparam logic [2:0] ARB_RD_ISSUE = 3'd1;
   localparam logic [2:0] ARB_RD_CAPT  = 3'd2;
   localparam logic [2:0] ARB_WR_ISSUE = 3'd3;
   localparam logic [2:0] ARB_DONE     = 3'd4;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector. Bit OWN_FETCH is the fetch unit, bit
// OWN_DATA the data unit. On a tie the requester that was not granted
// last wins. Purely combinational; the caller holds last_grant.
module rr_pick2
   import cpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant from the request pair and the previous owner
   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == OWN_DATA) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between the instruction-fetch unit (read-only) and the
// data/stack unit (read/write) sharing one registered single-port memory.
// Every output is registered, so requests never reach the strobes
// combinationally.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_done,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_abus,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din,
   output logic              memrd,
   output logic              memwr,
   output logic              busy
);

   logic [2:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [1:0]        grant;
   logic [ADDR_W-1:0] abus_d;
   logic [DATA_W-1:0] dout_d;
   logic [DATA_W-1:0] f_rdata_d, d_rdata_d;
   logic              memrd_d, memwr_d;
   logic              f_done_d, d_done_d;
   logic              busy_d;

   rr_pick2 u_pick (
      .req        ({d_req, f_req}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   // Next-state and next-output decode; strobes and done pulses default low
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      abus_d       = mem_abus;
      dout_d       = mem_dout;
      f_rdata_d    = f_rdata;
      d_rdata_d    = d_rdata;
      memrd_d      = 1'b0;
      memwr_d      = 1'b0;
      f_done_d     = 1'b0;
      d_done_d     = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant[OWN_DATA]) begin
               owner_d      = OWN_DATA;
               last_grant_d = OWN_DATA;
               abus_d       = d_addr;
               if (d_we) begin
                  dout_d  = d_wdata;
                  memwr_d = 1'b1;
                  state_d = ARB_WR_ISSUE;
               end else begin
                  memrd_d = 1'b1;
                  state_d = ARB_RD_ISSUE;
               end
            end else if (grant[OWN_FETCH]) begin
               owner_d      = OWN_FETCH;
               last_grant_d = OWN_FETCH;
               abus_d       = f_addr;
               memrd_d      = 1'b1;
               state_d      = ARB_RD_ISSUE;
            end
         end
         // Memory samples memrd on the edge leaving this state
         ARB_RD_ISSUE: state_d = ARB_RD_CAPT;
         ARB_RD_CAPT: begin
            if (owner_q == OWN_DATA) begin
               d_rdata_d = mem_din;
               d_done_d  = 1'b1;
            end else begin
               f_rdata_d = mem_din;
               f_done_d  = 1'b1;
            end
            state_d = ARB_DONE;
         end
         ARB_WR_ISSUE: begin
            d_done_d = 1'b1;
            state_d  = ARB_DONE;
         end
         // Turnaround cycle so a finished requester can drop req
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   // State and registered outputs; synchronous reset aborts any transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_FETCH;
         last_grant_q <= OWN_DATA;
         mem_abus     <= '0;
         mem_dout     <= '0;
         f_rdata      <= '0;
         d_rdata      <= '0;
         memrd        <= 1'b0;
         memwr        <= 1'b0;
         f_done       <= 1'b0;
         d_done       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_abus     <= abus_d;
         mem_dout     <= dout_d;
         f_rdata      <= f_rdata_d;
         d_rdata      <= d_rdata_d;
         memrd        <= memrd_d;
         memwr        <= memwr_d;
         f_done       <= f_done_d;
         d_done       <= d_done_d;
         busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected strobes and
// completions; monitors on the falling edge pop and compare.
module tb_mem_arbiter;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = '0;
   logic        f_done;
   logic [15:0] f_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_done;
   logic [15:0] d_rdata;
   logic [15:0] mem_abus;
   logic [15:0] mem_dout;
   logic [15:0] mem_din = '0;
   logic        memrd;
   logic        memwr;
   logic        busy;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } strobe_t;

   typedef struct packed {
      logic        owner;
      logic        we;
      logic [15:0] rdata;
   } done_t;

   strobe_t sq[$];
   done_t   dq[$];
   strobe_t s_exp;
   done_t   d_exp;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int strobe_cyc = 0;
   int done_count = 0;
   logic prev_strobe = 1'b0;
   logic prev_fd = 1'b0;
   logic prev_dd = 1'b0;
   logic [15:0] mem [16];

   mem_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_done   (f_done),
      .f_rdata  (f_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_done   (d_done),
      .d_rdata  (d_rdata),
      .mem_abus (mem_abus),
      .mem_dout (mem_dout),
      .mem_din  (mem_din),
      .memrd    (memrd),
      .memwr    (memwr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered single-port 16x16 memory, low four address bits decoded
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
      mem[0]  = 16'hF000;
      mem[1]  = 16'h1234;
      mem[2]  = 16'h5678;
      mem[14] = 16'h0003;
      forever begin
         @(posedge clk);
         if (memwr) mem[mem_abus[3:0]] <= mem_dout;
         if (memrd) mem_din <= mem[mem_abus[3:0]];
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, got, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: event seen, none required", name);
   endtask

   // Strobe and completion monitor
   always @(negedge clk) begin
      if (memrd || memwr) begin
         check("strobe_exclusive", 32'(memrd && memwr), 32'd0);
         check("strobe_width", 32'(prev_strobe), 32'd0);
         if (sq.size() == 0) fail_now("unexpected_strobe");
         else begin
            s_exp = sq.pop_front();
            check("strobe_kind", 32'(memwr), 32'(s_exp.we));
            check("strobe_addr", 32'(mem_abus), 32'(s_exp.addr));
            if (s_exp.we) check("strobe_wdata", 32'(mem_dout), 32'(s_exp.wdata));
         end
         strobe_cyc = cyc;
      end
      prev_strobe = memrd || memwr;
      if (f_done || d_done) begin
         if (f_done && d_done) fail_now("both_done");
         check("done_width", 32'(f_done ? prev_fd : prev_dd), 32'd0);
         if (dq.size() == 0) fail_now("unexpected_done");
         else begin
            d_exp = dq.pop_front();
            check("done_owner", 32'(d_done), 32'(d_exp.owner));
            check("rdata", 32'(d_done ? d_rdata : f_rdata), 32'(d_exp.rdata));
            check("latency", 32'(cyc - strobe_cyc), d_exp.we ? 32'd1 : 32'd2);
         end
         done_count++;
      end
      prev_fd = f_done;
      prev_dd = d_done;
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (done_count >= target) return;
      end
      n_checks++;
      $display("FAIL %s: timeout, done count %0d, required %0d", name, done_count, target);
   endtask

   task automatic do_txn(input logic own, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd,
                         input string name);
      int tgt;
      sq.push_back('{we: we, addr: addr, wdata: wdata});
      dq.push_back('{owner: own, we: we, rdata: exp_rd});
      tgt = done_count + 1;
      if (own == OWN_DATA) begin
         d_we    = we;
         d_addr  = addr;
         d_wdata = wdata;
         d_req   = 1'b1;
      end else begin
         f_addr = addr;
         f_req  = 1'b1;
      end
      wait_done(tgt, name);
      f_req = 1'b0;
      d_req = 1'b0;
      wait_cycles(2);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(1);
   endtask

   initial begin
      int tgt;
      bit seen;
      wait_cycles(3);
      check("reset_f_rdata", 32'(f_rdata), 32'd0);
      check("reset_d_rdata", 32'(d_rdata), 32'd0);
      check("reset_strobes", 32'({memrd, memwr}), 32'd0);
      check("reset_done", 32'({f_done, d_done}), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_abus", 32'(mem_abus), 32'd0);
      reset = 1'b0;
      wait_cycles(1);

      // Single fetch, data write, read-back, fetch of the written word
      do_txn(OWN_FETCH, 1'b0, 16'd0, 16'h0000, 16'hF000, "fetch0");
      do_txn(OWN_DATA, 1'b1, 16'd5, 16'hABCD, 16'h0000, "write5");
      do_txn(OWN_DATA, 1'b0, 16'd5, 16'h0000, 16'hABCD, "read5");
      do_txn(OWN_FETCH, 1'b0, 16'd5, 16'h0000, 16'hABCD, "fetch5");

      // Simultaneous requests after reset: fetch first, then strict alternation
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         sq.push_back('{we: 1'b0, addr: 16'd1, wdata: 16'h0000});
         dq.push_back('{owner: OWN_FETCH, we: 1'b0, rdata: 16'h1234});
         sq.push_back('{we: 1'b0, addr: 16'd14, wdata: 16'h0000});
         dq.push_back('{owner: OWN_DATA, we: 1'b0, rdata: 16'h0003});
      end
      tgt    = done_count + 4;
      f_addr = 16'd1;
      d_addr = 16'd14;
      d_we   = 1'b0;
      f_req  = 1'b1;
      d_req  = 1'b1;
      wait_done(tgt, "alternate");
      f_req = 1'b0;
      d_req = 1'b0;
      wait_cycles(2);

      // Reset while the read strobe is out: abort with no completion
      sq.push_back('{we: 1'b0, addr: 16'd2, wdata: 16'h0000});
      f_addr = 16'd2;
      f_req  = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (memrd) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL abort_wait: timeout, memrd 0, required 1");
      end
      reset = 1'b1;
      f_req = 1'b0;
      wait_cycles(1);
      check("abort_memrd", 32'(memrd), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_f_done", 32'(f_done), 32'd0);
      check("abort_f_rdata", 32'(f_rdata), 32'd0);
      reset = 1'b0;
      wait_cycles(6);

      check("strobe_queue_empty", 32'(sq.size()), 32'd0);
      check("done_queue_empty", 32'(dq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
